seq_scan_ctrl: RTL and testbench
================================

Name: seq_scan_ctrl

Overview:
- Sequencer for the switch-scan sequence detector datapath.
- Replaces the free-running divided clock and mux-select counter with a single-clock controller:
  - generates the bit index that selects one switch bit per step;
  - issues one-cycle step enables to the detector FSM;
  - clears the FSM at frame start;
  - latches the per-frame detect result that picks the good/bad display message.
- Supports single-shot and continuous scanning.

Parameters:
- TICK_DIV, 25000000: clk cycles per scan step (minimum 2). Bench uses 4.
- NBITS, 8: switch bits per frame (index width = clog2(NBITS)).

Ports:
- clk  input  1  system clock; all state on rising edge.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  raw button; synchronized internally; rising edge begins a scan.
- abort  input  1  synchronous level; stops scanning.
- mode_cont  input  1  0 = single frame, 1 = repeat frames until abort. Sampled at the start edge only.
- fsm_z  input  1  detector output, registered in the detector on step.
- bit_sel  output  clog2(NBITS)  switch mux select.
- step  output  1  one-cycle enable; detector consumes switches[bit_sel] on this cycle.
- fsm_clr  output  1  one-cycle synchronous clear to the detector.
- leds  output  NBITS  one-hot position indicator.
- busy  output  1  high in CLR and SCAN.
- frame_done  output  1  one-cycle pulse at frame end.
- detect  output  1  result of the last completed frame.

Behaviour:
- Reset asserted (reset=0), async:
  - state IDLE; bit_sel=0, step=0, fsm_clr=0, leds=0, busy=0, frame_done=0, detect=0.
  - Tick counter=0, synchronizer flops=0, hit=0.
- start path: 2-flop synchronizer plus edge register. start_pulse occurs on the 3rd clk edge after start rises. Button held high produces one pulse only.
- States: IDLE, CLR, SCAN, DONE.
- IDLE or DONE:
  - on start_pulse: go to CLR; latch mode_cont.
  - detect holds its value.
- CLR (exactly one cycle):
  - fsm_clr=1, busy=1, bit_sel=0, hit=0, tick counter=0.
  - Next state SCAN.
- SCAN:
  - Tick counter runs 0..TICK_DIV-1.
  - At count TICK_DIV-1: step=1 for that cycle, with bit_sel = current index.
  - The cycle after step: sample fsm_z; if 1, set hit (sticky within the frame). Index then increments.
  - First step occurs TICK_DIV cycles after CLR.
  - Last-bit handling, on the fsm_z sample cycle after the step with index NBITS-1:
    - detect <= hit OR fsm_z;
    - frame_done=1 for one cycle;
    - bit_sel wraps to 0;
    - single mode: go to DONE;
    - continuous mode: hit=0; stay in SCAN; no fsm_clr, so the detector history carries across frames.
- abort=1 in CLR or SCAN:
  - next cycle go to IDLE; bit_sel=0, hit=0.
  - No frame_done; detect unchanged.
  - abort has priority over a simultaneous step or start_pulse.
- start_pulse during CLR or SCAN is ignored.
- leds: leds[bit_sel]=1 while busy; otherwise all 0.
- busy=0 in IDLE and DONE.
- Outputs are registered except step and fsm_clr, which are decoded from registered state only (no input-to-output combinational path).

Decomposition:
- Shared package:
  - state encoding (IDLE=0, CLR=1, SCAN=2, DONE=3);
  - default NBITS;
  - simulation TICK_DIV constant.
- Sub-module scan_tick_gen (parameter TICK_DIV):
  - inputs: clk, reset, clr;
  - output: tick (one-cycle pulse every TICK_DIV cycles, restarted by clr).
- The controller FSM, index counter, synchronizer and result latch stay in seq_scan_ctrl.

Test Plan:
- Reset mid-scan: pull reset low at any point → all outputs 0 immediately (async), without waiting for a clock edge.
- Single frame, TICK_DIV=4, mode_cont=0, fsm_z model detects at bit 5:
  - start pulse → fsm_clr 1 cycle;
  - 8 step pulses spaced 4 cycles, bit_sel 0..7;
  - leds 0x01..0x80;
  - frame_done once; detect=1; busy=0; state DONE.
- Single frame with fsm_z stuck 0 → detect=0 after frame_done. Then a second start with a hit at bit 7 → detect=1, updated exactly on the frame_done cycle.
- Continuous mode, TICK_DIV=4:
  - frame 1 hit, frame 2 no hit;
  - detect reads 1 then 0 at successive frame_done pulses, 32 cycles apart;
  - no fsm_clr between frames.
- Abort at bit_sel=3, coincident with step:
  - next cycle IDLE; bit_sel=0; leds=0;
  - no frame_done; detect keeps its prior value.
- Start held high 100 cycles, plus a 1-cycle glitch on start during SCAN → exactly one CLR; the scan is not restarted.

Source files
------------

// File: rtl/seq_scan_ctrl_pkg.sv
// Shared definitions for the switch-scan sequencer: state encoding and default sizing.

package seq_scan_ctrl_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StClr  = 2'd1,
        StScan = 2'd2,
        StDone = 2'd3
    } scan_state_e;

    localparam int unsigned NBitsDefault = 8;
    localparam int unsigned SimTickDiv   = 4;

endpackage

// File: rtl/seq_scan_ctrl_if.sv
// Handshake bundle between the scan sequencer (slave) and its user/detector side (master).

interface seq_scan_ctrl_if
    import seq_scan_ctrl_pkg::*;
#(
    parameter int unsigned NBITS = NBitsDefault
);
    localparam int unsigned IdxW = (NBITS > 1) ? $clog2(NBITS) : 1;

    logic            start;
    logic            abort;
    logic            mode_cont;
    logic            fsm_z;
    logic [IdxW-1:0] bit_sel;
    logic            step;
    logic            fsm_clr;
    logic [NBITS-1:0] leds;
    logic            busy;
    logic            frame_done;
    logic            detect;

    modport slave (
        input  start, abort, mode_cont, fsm_z,
        output bit_sel, step, fsm_clr, leds, busy, frame_done, detect
    );

    modport master (
        output start, abort, mode_cont, fsm_z,
        input  bit_sel, step, fsm_clr, leds, busy, frame_done, detect
    );

endinterface

// File: rtl/seq_scan_ctrl_tick_gen.sv
// Step-rate divider: one-cycle tick every TICK_DIV cycles, restarted from zero by clr_i.

module scan_tick_gen #(
    parameter int unsigned TICK_DIV = 4
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clr_i,
    output logic tick_o
);
    localparam int unsigned CntW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(TICK_DIV - 1);

    logic [CntW-1:0] cnt_q, cnt_d;

    assign tick_o = (cnt_q == CntMax);

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (clr_i || tick_o) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/seq_scan_ctrl.sv
// Single-clock scan sequencer: drives the switch mux select, steps/clears the detector FSM
// and latches the per-frame detect result.

module seq_scan_ctrl
    import seq_scan_ctrl_pkg::*;
#(
    parameter int unsigned TICK_DIV = 25000000,
    parameter int unsigned NBITS    = NBitsDefault
) (
    input logic            clk_i,
    input logic            rst_ni,
    seq_scan_ctrl_if.slave scan_io
);
    localparam int unsigned IdxW = (NBITS > 1) ? $clog2(NBITS) : 1;
    localparam logic [IdxW-1:0] IdxLast = IdxW'(NBITS - 1);

    scan_state_e state_q, state_d;

    logic            sync1_q, sync2_q, edge_q;
    logic            start_pulse;
    logic [IdxW-1:0] idx_q, idx_d;
    logic            hit_q, hit_d;
    logic            mode_q, mode_d;
    logic            samp_q, samp_d;
    logic            detect_q, detect_d;
    logic            frame_done_q, frame_done_d;
    logic            busy_q, busy_d;
    logic [NBITS-1:0] leds_q, leds_d;

    logic tick;
    logic tick_clr;
    logic step;
    logic last_idx;

    assign start_pulse = sync2_q & ~edge_q;
    // Counter held at zero outside SCAN so the first step lands TICK_DIV cycles after CLR.
    assign tick_clr    = (state_q != StScan);
    assign step        = (state_q == StScan) & tick;
    assign last_idx    = (idx_q == IdxLast);

    scan_tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_gen (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .clr_i  (tick_clr),
        .tick_o (tick)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle, StDone: begin
                if (start_pulse) begin
                    state_d = StClr;
                end
            end
            StClr: begin
                state_d = scan_io.abort ? StIdle : StScan;
            end
            StScan: begin
                if (scan_io.abort) begin
                    state_d = StIdle;
                end else if (samp_q && last_idx && !mode_q) begin
                    state_d = StDone;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        idx_d        = idx_q;
        hit_d        = hit_q;
        mode_d       = mode_q;
        samp_d       = 1'b0;
        detect_d     = detect_q;
        frame_done_d = 1'b0;
        unique case (state_q)
            StIdle, StDone: begin
                if (start_pulse) begin
                    mode_d = scan_io.mode_cont;
                end
            end
            StClr: begin
                idx_d = '0;
                hit_d = 1'b0;
            end
            StScan: begin
                if (scan_io.abort) begin
                    idx_d = '0;
                    hit_d = 1'b0;
                end else begin
                    samp_d = step;
                    // fsm_z reflects the bit consumed on the preceding step cycle.
                    if (samp_q) begin
                        hit_d = hit_q | scan_io.fsm_z;
                        if (last_idx) begin
                            detect_d     = hit_q | scan_io.fsm_z;
                            frame_done_d = 1'b1;
                            idx_d        = '0;
                            if (mode_q) begin
                                hit_d = 1'b0;
                            end
                        end else begin
                            idx_d = idx_q + 1'b1;
                        end
                    end
                end
            end
            default: begin
                idx_d = '0;
                hit_d = 1'b0;
            end
        endcase
    end

    always_comb begin
        busy_d = (state_d == StClr) || (state_d == StScan);
        leds_d = '0;
        if (busy_d) begin
            leds_d[idx_d] = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync1_q      <= 1'b0;
            sync2_q      <= 1'b0;
            edge_q       <= 1'b0;
            idx_q        <= '0;
            hit_q        <= 1'b0;
            mode_q       <= 1'b0;
            samp_q       <= 1'b0;
            detect_q     <= 1'b0;
            frame_done_q <= 1'b0;
            busy_q       <= 1'b0;
            leds_q       <= '0;
        end else begin
            sync1_q      <= scan_io.start;
            sync2_q      <= sync1_q;
            edge_q       <= sync2_q;
            idx_q        <= idx_d;
            hit_q        <= hit_d;
            mode_q       <= mode_d;
            samp_q       <= samp_d;
            detect_q     <= detect_d;
            frame_done_q <= frame_done_d;
            busy_q       <= busy_d;
            leds_q       <= leds_d;
        end
    end

    assign scan_io.bit_sel    = idx_q;
    assign scan_io.step       = step;
    assign scan_io.fsm_clr    = (state_q == StClr);
    assign scan_io.leds       = leds_q;
    assign scan_io.busy       = busy_q;
    assign scan_io.frame_done = frame_done_q;
    assign scan_io.detect     = detect_q;

endmodule

// File: tb/tb_seq_scan_ctrl.sv
// Scoreboard bench for seq_scan_ctrl with a behavioural detector driven by per-frame hit masks.

module tb_seq_scan_ctrl;
    import seq_scan_ctrl_pkg::*;

    localparam int unsigned NB = 8;

    logic clk;
    logic rst_n;

    seq_scan_ctrl_if #(.NBITS(NB)) bus ();

    seq_scan_ctrl #(
        .TICK_DIV (SimTickDiv),
        .NBITS    (NB)
    ) dut (
        .clk_i   (clk),
        .rst_ni  (rst_n),
        .scan_io (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    // Detector model: registers the hit flag for the consumed bit on each step.
    logic [NB-1:0] mask_q[$];
    logic          z;
    assign bus.fsm_z = z;

    always @(posedge clk) begin
        if (!rst_n) begin
            z <= 1'b0;
        end else if (bus.fsm_clr) begin
            z <= 1'b0;
        end else if (bus.step) begin
            z <= (mask_q.size() > 0) ? mask_q[0][bus.bit_sel] : 1'b0;
            if (bus.bit_sel == 3'(NB - 1) && mask_q.size() > 1) void'(mask_q.pop_front());
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc++;

    // Scoreboard: expected step indices and {busy, detect} at each frame_done.
    int   exp_step_q[$];
    logic [1:0] exp_fd_q[$];
    logic model_det = 1'b0;
    logic det_prev  = 1'b0;
    int   last_evt  = 0;
    int   clr_cnt   = 0;

    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.fsm_clr) begin
                clr_cnt++;
                last_evt = cyc;
            end
            if (bus.step) begin
                if (exp_step_q.size() == 0) begin
                    check_eq("step_unexpected", 1, 0);
                end else begin
                    int e;
                    logic [NB-1:0] oh;
                    e  = exp_step_q.pop_front();
                    oh = NB'(1) << e;
                    check_eq("step_bit_sel", 32'(bus.bit_sel), 32'(e));
                    check_eq("step_leds", 32'(bus.leds), 32'(oh));
                    check_eq("step_gap", 32'(cyc - last_evt), 32'(SimTickDiv));
                end
                last_evt = cyc;
            end
            if (bus.frame_done) begin
                if (exp_fd_q.size() == 0) begin
                    check_eq("frame_done_unexpected", 1, 0);
                end else begin
                    logic [1:0] e;
                    e = exp_fd_q.pop_front();
                    check_eq("fd_detect_before", 32'(det_prev), 32'(model_det));
                    check_eq("fd_detect", 32'(bus.detect), 32'(e[0]));
                    check_eq("fd_busy", 32'(bus.busy), 32'(e[1]));
                    model_det = e[0];
                end
            end else begin
                check_eq("detect_hold", 32'(bus.detect), 32'(model_det));
            end
            det_prev = bus.detect;
        end
    end

    task automatic push_frame(input int nsteps, input logic busy_e, input logic det_e,
                              input logic with_fd);
        for (int i = 0; i < nsteps; i++) exp_step_q.push_back(i);
        if (with_fd) exp_fd_q.push_back({busy_e, det_e});
    endtask

    task automatic wait_fd(input int budget, output int at);
        at = -1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (bus.frame_done) begin
                at = cyc;
                break;
            end
        end
        if (at < 0) check_eq("frame_done_timeout", 0, 1);
    endtask

    task automatic pulse_start();
        int seen;
        seen = 0;
        bus.start = 1'b1;
        for (int i = 0; i < 10 && seen == 0; i++) begin
            @(negedge clk);
            if (bus.fsm_clr) seen = 1;
        end
        check_eq("clr_seen", 32'(seen), 1);
        bus.start = 1'b0;
    endtask

    task automatic check_idle_outputs(input string tag);
        check_eq({tag, "_busy"}, 32'(bus.busy), 0);
        check_eq({tag, "_bit_sel"}, 32'(bus.bit_sel), 0);
        check_eq({tag, "_leds"}, 32'(bus.leds), 0);
    endtask

    initial begin
        int t1, t2, found;
        bus.start     = 1'b0;
        bus.abort     = 1'b0;
        bus.mode_cont = 1'b0;
        rst_n         = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        check_eq("rst_bit_sel", 32'(bus.bit_sel), 0);
        check_eq("rst_step", 32'(bus.step), 0);
        check_eq("rst_fsm_clr", 32'(bus.fsm_clr), 0);
        check_eq("rst_leds", 32'(bus.leds), 0);
        check_eq("rst_busy", 32'(bus.busy), 0);
        check_eq("rst_frame_done", 32'(bus.frame_done), 0);
        check_eq("rst_detect", 32'(bus.detect), 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        // Single frame, hit at bit 5, start held through the frame; checks sync latency.
        mask_q = {8'h20};
        push_frame(8, 1'b0, 1'b1, 1'b1);
        bus.start = 1'b1;
        @(posedge clk); @(posedge clk); #1;
        check_eq("clr_early", 32'(bus.fsm_clr), 0);
        @(posedge clk); #1;
        check_eq("clr_latency", 32'(bus.fsm_clr), 1);
        check_eq("clr_busy", 32'(bus.busy), 1);
        @(posedge clk); #1;
        check_eq("clr_one_cycle", 32'(bus.fsm_clr), 0);
        wait_fd(100, t1);
        check_idle_outputs("single_done");
        @(negedge clk);
        bus.start = 1'b0;
        repeat (10) @(negedge clk);
        check_eq("single_steps_left", 32'(exp_step_q.size()), 0);
        check_eq("single_fd_left", 32'(exp_fd_q.size()), 0);

        // No hit, then a hit on the final bit.
        mask_q = {8'h00};
        push_frame(8, 1'b0, 1'b0, 1'b1);
        pulse_start();
        wait_fd(100, t1);
        repeat (4) @(negedge clk);
        mask_q = {8'h80};
        push_frame(8, 1'b0, 1'b1, 1'b1);
        pulse_start();
        wait_fd(100, t1);
        repeat (4) @(negedge clk);

        // Continuous: hit then no hit; mode changes after the start edge must be ignored.
        mask_q = {8'h04, 8'h00};
        push_frame(8, 1'b1, 1'b1, 1'b1);
        push_frame(8, 1'b1, 1'b0, 1'b1);
        clr_cnt = 0;
        bus.mode_cont = 1'b1;
        pulse_start();
        bus.mode_cont = 1'b0;
        wait_fd(100, t1);
        wait_fd(100, t2);
        bus.abort = 1'b1;
        @(negedge clk);
        bus.abort = 1'b0;
        check_eq("cont_gap", 32'(t2 - t1), 32'(NB * SimTickDiv));
        check_eq("cont_clr_count", 32'(clr_cnt), 1);
        check_idle_outputs("cont_abort");
        repeat (10) @(negedge clk);
        check_eq("cont_steps_left", 32'(exp_step_q.size()), 0);

        // Abort coincident with the step at bit 3; a completed frame would have set detect.
        mask_q = {8'h02};
        push_frame(4, 1'b0, 1'b0, 1'b0);
        pulse_start();
        found = 0;
        for (int i = 0; i < 100 && found == 0; i++) begin
            if (bus.step && bus.bit_sel == 3'd3) begin
                found = 1;
            end else begin
                @(negedge clk);
            end
        end
        check_eq("abort_step_found", 32'(found), 1);
        bus.abort = 1'b1;
        @(posedge clk); #1;
        check_idle_outputs("abort");
        check_eq("abort_step", 32'(bus.step), 0);
        @(negedge clk);
        bus.abort = 1'b0;
        repeat (40) @(negedge clk);
        check_idle_outputs("abort_late");
        check_eq("abort_detect", 32'(bus.detect), 0);
        check_eq("abort_steps_left", 32'(exp_step_q.size()), 0);

        // Start held 100 cycles with a one-cycle glitch mid-scan: exactly one frame.
        mask_q = {8'h10};
        push_frame(8, 1'b0, 1'b1, 1'b1);
        clr_cnt = 0;
        bus.start = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (i == 20) bus.start = 1'b0;
            if (i == 21) bus.start = 1'b1;
        end
        bus.start = 1'b0;
        repeat (20) @(negedge clk);
        check_eq("glitch_clr_count", 32'(clr_cnt), 1);
        check_eq("glitch_steps_left", 32'(exp_step_q.size()), 0);
        check_eq("glitch_fd_left", 32'(exp_fd_q.size()), 0);
        check_idle_outputs("glitch_done");

        // Asynchronous reset mid-scan, away from any clock edge.
        mask_q = {8'hff};
        push_frame(8, 1'b1, 1'b1, 1'b1);
        bus.mode_cont = 1'b1;
        pulse_start();
        bus.mode_cont = 1'b0;
        found = 0;
        for (int i = 0; i < 100 && found == 0; i++) begin
            @(negedge clk);
            if (bus.step && bus.bit_sel == 3'd2) found = 1;
        end
        check_eq("rst_mid_found", 32'(found), 1);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check_eq("rst_mid_bit_sel", 32'(bus.bit_sel), 0);
        check_eq("rst_mid_step", 32'(bus.step), 0);
        check_eq("rst_mid_fsm_clr", 32'(bus.fsm_clr), 0);
        check_eq("rst_mid_leds", 32'(bus.leds), 0);
        check_eq("rst_mid_busy", 32'(bus.busy), 0);
        check_eq("rst_mid_frame_done", 32'(bus.frame_done), 0);
        check_eq("rst_mid_detect", 32'(bus.detect), 0);
        exp_step_q.delete();
        exp_fd_q.delete();
        model_det = 1'b0;
        det_prev  = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        check_idle_outputs("post_reset");

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
